// File: rtl/alu_8bit_arb_if.sv
// Requester and response handshake bundle for the two-client shared-ALU arbiter.
// The master side is the client/consumer; the slave side is the arbiter.
interface alu_8bit_arb_if;
  logic       req0_valid;
  logic       req0_ready;
  logic [7:0] req0_a;
  logic [7:0] req0_b;
  logic [3:0] req0_opcode;

  logic       req1_valid;
  logic       req1_ready;
  logic [7:0] req1_a;
  logic [7:0] req1_b;
  logic [3:0] req1_opcode;

  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_id;
  logic [7:0] rsp_result;
  logic [7:0] rsp_carry;

  modport master (
    output req0_valid, req0_a, req0_b, req0_opcode,
    output req1_valid, req1_a, req1_b, req1_opcode,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_carry
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_opcode,
    input  req1_valid, req1_a, req1_b, req1_opcode,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_carry
  );
endinterface

// File: rtl/alu_8bit_arb.sv
// Round-robin arbiter/sequencer sharing one combinational 8-bit ALU between two
// requesters; one operation in flight, result returned tagged with requester ID.
module alu_8bit_arb #(
  parameter int EXEC_CYCLES = 1
) (
  input  logic           clk,
  input  logic           rst,
  alu_8bit_arb_if.slave  bus,
  output logic [7:0]     alu_a,
  output logic [7:0]     alu_b,
  output logic [3:0]     alu_opcode,
  input  logic [7:0]     alu_result,
  input  logic [7:0]     alu_carry,
  output logic           busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] LAST_CNT = 4'(EXEC_CYCLES - 1);

  logic [1:0] state;
  logic [3:0] cnt;
  logic       last_grant;
  logic       grant0;
  logic       grant1;
  logic       rsp_id_r;
  logic [7:0] rsp_result_r;
  logic [7:0] rsp_carry_r;

  // Under contention the requester that did not win last time is granted.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant0 = last_grant;
        grant1 = ~last_grant;
      end else begin
        grant0 = bus.req0_valid;
        grant1 = bus.req1_valid;
      end
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.rsp_valid  = (state == DONE);
  assign bus.rsp_id     = rsp_id_r;
  assign bus.rsp_result = rsp_result_r;
  assign bus.rsp_carry  = rsp_carry_r;
  assign busy           = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      last_grant   <= 1'b1;
      alu_a        <= 8'd0;
      alu_b        <= 8'd0;
      alu_opcode   <= 4'd0;
      rsp_id_r     <= 1'b0;
      rsp_result_r <= 8'd0;
      rsp_carry_r  <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            alu_a      <= grant1 ? bus.req1_a      : bus.req0_a;
            alu_b      <= grant1 ? bus.req1_b      : bus.req0_b;
            alu_opcode <= grant1 ? bus.req1_opcode : bus.req0_opcode;
            rsp_id_r   <= grant1;
            last_grant <= grant1;
            cnt        <= 4'd0;
            state      <= EXEC;
          end
        end
        EXEC: begin
          cnt <= cnt + 4'd1;
          if (cnt == LAST_CNT) begin
            rsp_result_r <= alu_result;
            rsp_carry_r  <= alu_carry;
            state        <= DONE;
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_8bit_arb.sv
// Bench for alu_8bit_arb: two instances (1 and 4 exec cycles) share stimulus and are
// compared every cycle against a transaction-level model, plus hand-computed pins.
module tb_alu_8bit_arb;
  localparam int EXEC_A = 1;
  localparam int EXEC_B = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       r0v, r1v, rspReady;
  logic [7:0] r0a, r0b, r1a, r1b;
  logic [3:0] r0op, r1op;

  int checks = 0;
  int errors = 0;
  bit checkEn = 1'b0;

  alu_8bit_arb_if bus0();
  alu_8bit_arb_if bus1();

  assign bus0.req0_valid = r0v;  assign bus1.req0_valid = r0v;
  assign bus0.req0_a = r0a;      assign bus1.req0_a = r0a;
  assign bus0.req0_b = r0b;      assign bus1.req0_b = r0b;
  assign bus0.req0_opcode = r0op; assign bus1.req0_opcode = r0op;
  assign bus0.req1_valid = r1v;  assign bus1.req1_valid = r1v;
  assign bus0.req1_a = r1a;      assign bus1.req1_a = r1a;
  assign bus0.req1_b = r1b;      assign bus1.req1_b = r1b;
  assign bus0.req1_opcode = r1op; assign bus1.req1_opcode = r1op;
  assign bus0.rsp_ready = rspReady; assign bus1.rsp_ready = rspReady;

  logic [7:0] a0, b0, res0, car0, a1, b1, res1, car1;
  logic [3:0] op0, op1;
  logic       busy0, busy1;

  // Stand-in for the shared alu_8bit: returns {carry, result}.
  function automatic logic [15:0] aluFunc(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] op);
    logic [8:0]  s;
    logic [15:0] p;
    case (op)
      4'd0:  begin s = {1'b0, a} + {1'b0, b}; return {7'd0, s[8], s[7:0]}; end
      4'd1:  begin s = {1'b0, a} - {1'b0, b}; return {7'd0, s[8], s[7:0]}; end
      4'd2:  return {8'd0, a & b};
      4'd3:  return {8'd0, a | b};
      4'd4:  return {8'd0, a ^ b};
      4'd5:  return {8'd0, ~a};
      4'd6:  return {7'd0, a[7], a[6:0], 1'b0};
      4'd7:  return {7'd0, a[0], 1'b0, a[7:1]};
      4'd8:  begin p = a * b; return p; end
      4'd9:  return {8'd0, b};
      4'd10: return {8'd0, a};
      4'd11: begin s = {1'b0, a} + 9'd1; return {7'd0, s[8], s[7:0]}; end
      4'd12: return {8'd0, ~(a & b)};
      4'd13: return {8'd0, ~(a | b)};
      4'd14: return {15'd0, a < b};
      default: return {a, b};
    endcase
  endfunction

  assign {car0, res0} = aluFunc(a0, b0, op0);
  assign {car1, res1} = aluFunc(a1, b1, op1);

  alu_8bit_arb #(.EXEC_CYCLES(EXEC_A)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0),
    .alu_a(a0), .alu_b(b0), .alu_opcode(op0),
    .alu_result(res0), .alu_carry(car0), .busy(busy0)
  );

  alu_8bit_arb #(.EXEC_CYCLES(EXEC_B)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1),
    .alu_a(a1), .alu_b(b1), .alu_opcode(op1),
    .alu_result(res1), .alu_carry(car1), .busy(busy1)
  );

  // Transaction-level model: an instance is either free or owns one operation whose
  // response appears a fixed number of cycles after acceptance and waits for the consumer.
  bit         mBusy[2], mDone[2], mLast[2], mId[2];
  int         mCount[2];
  logic [7:0] mA[2], mB[2], mRes[2], mCar[2];
  logic [3:0] mOp[2];

  function automatic int execOf(input int i);
    return (i == 0) ? EXEC_A : EXEC_B;
  endfunction

  function automatic bit expReady(input int i, input int n);
    if (mBusy[i]) return 1'b0;
    if (n == 0) return r0v && (!r1v || mLast[i]);
    return r1v && (!r0v || !mLast[i]);
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bit g0, g1;
      g0 = expReady(i, 0);
      g1 = expReady(i, 1);
      if (rst) begin
        mBusy[i] = 0; mDone[i] = 0; mLast[i] = 1; mId[i] = 0; mCount[i] = 0;
        mA[i] = 0; mB[i] = 0; mOp[i] = 0; mRes[i] = 0; mCar[i] = 0;
      end else if (!mBusy[i]) begin
        if (g0 || g1) begin
          mId[i] = g1; mLast[i] = g1;
          mA[i] = g1 ? r1a : r0a; mB[i] = g1 ? r1b : r0b; mOp[i] = g1 ? r1op : r0op;
          mBusy[i] = 1; mCount[i] = execOf(i);
        end
      end else if (mCount[i] > 0) begin
        mCount[i]--;
        if (mCount[i] == 0) begin
          {mCar[i], mRes[i]} = aluFunc(mA[i], mB[i], mOp[i]);
          mDone[i] = 1;
        end
      end else if (rspReady) begin
        mDone[i] = 0; mBusy[i] = 0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compareInst(input int i, input logic rdy0, input logic rdy1,
                             input logic rv, input logic id, input logic bz,
                             input logic [7:0] res, input logic [7:0] car,
                             input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    checkOutput($sformatf("dut%0d.req0_ready", i), rdy0, expReady(i, 0));
    checkOutput($sformatf("dut%0d.req1_ready", i), rdy1, expReady(i, 1));
    checkOutput($sformatf("dut%0d.rsp_valid", i), rv, mDone[i]);
    checkOutput($sformatf("dut%0d.busy", i), bz, mBusy[i]);
    checkOutput($sformatf("dut%0d.rsp_id", i), id, mId[i]);
    checkOutput($sformatf("dut%0d.rsp_result", i), res, mRes[i]);
    checkOutput($sformatf("dut%0d.rsp_carry", i), car, mCar[i]);
    checkOutput($sformatf("dut%0d.alu_a", i), a, mA[i]);
    checkOutput($sformatf("dut%0d.alu_b", i), b, mB[i]);
    checkOutput($sformatf("dut%0d.alu_opcode", i), op, mOp[i]);
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      compareInst(0, bus0.req0_ready, bus0.req1_ready, bus0.rsp_valid, bus0.rsp_id, busy0,
                  bus0.rsp_result, bus0.rsp_carry, a0, b0, op0);
      compareInst(1, bus1.req0_ready, bus1.req1_ready, bus1.rsp_valid, bus1.rsp_id, busy1,
                  bus1.rsp_result, bus1.rsp_carry, a1, b1, op1);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic applyStimulus(input bit v0, input logic [7:0] a0i, input logic [7:0] b0i,
                               input logic [3:0] op0i, input bit v1, input logic [7:0] a1i,
                               input logic [7:0] b1i, input logic [3:0] op1i, input bit rr);
    r0v = v0; r0a = a0i; r0b = b0i; r0op = op0i;
    r1v = v1; r1a = a1i; r1b = b1i; r1op = op1i;
    rspReady = rr;
  endtask

  task automatic resetPulse();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  int  grants[$];
  bit  seen;
  bit  found;
  logic [7:0] heldRes;

  initial begin
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick(2);
    checkEn = 1'b1;
    settle();
    checkOutput("reset.busy", busy0, 0);
    checkOutput("reset.rsp_valid", bus0.rsp_valid, 0);
    checkOutput("reset.alu_a", a0, 0);
    rst = 1'b0;
    tick(1);

    // Single request: ADD AE+E6 from requester 0
    applyStimulus(1, 8'hAE, 8'hE6, 4'd0, 0, 0, 0, 0, 1);
    settle();
    checkOutput("single.req0_ready", bus0.req0_ready, 1);
    tick(1);
    r0v = 1'b0;
    settle();
    checkOutput("single.alu_a", a0, 8'hAE);
    checkOutput("single.alu_b", b0, 8'hE6);
    tick(1);
    settle();
    checkOutput("single.rsp_valid", bus0.rsp_valid, 1);
    checkOutput("single.rsp_result", bus0.rsp_result, 8'h94);
    checkOutput("single.rsp_carry", bus0.rsp_carry, 8'h01);
    checkOutput("single.rsp_id", bus0.rsp_id, 0);
    checkOutput("exec4.early_valid", bus1.rsp_valid, 0);
    checkOutput("exec4.alu_a_stable", a1, 8'hAE);
    tick(3);
    settle();
    checkOutput("exec4.rsp_valid", bus1.rsp_valid, 1);
    checkOutput("exec4.rsp_result", bus1.rsp_result, 8'h94);
    tick(4);

    // Contention from reset: grants must alternate starting with requester 0
    resetPulse();
    applyStimulus(1, 8'h10, 8'h20, 4'd0, 1, 8'h01, 8'h02, 4'd0, 1);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      settle();
      if (bus0.req0_ready) grants.push_back(0);
      if (bus0.req1_ready) grants.push_back(1);
      if (bus0.rsp_valid && bus0.rsp_id && !seen) begin
        checkOutput("contention.req1_result", bus0.rsp_result, 8'h03);
        seen = 1;
      end
      tick(1);
    end
    if (!seen) checkOutput("contention.req1_seen", 0, 1);
    if (grants.size() < 4) checkOutput("contention.grant_count", grants.size(), 4);
    for (int k = 0; k < 4 && k < grants.size(); k++)
      checkOutput($sformatf("contention.grant%0d", k), grants[k], k % 2);

    // Backpressure: 12*34 via MUL held while the consumer stalls
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick(10);
    applyStimulus(1, 8'h12, 8'h34, 4'd8, 0, 0, 0, 0, 0);
    tick(1);
    applyStimulus(0, 0, 0, 0, 1, 8'h55, 8'h0F, 4'd2, 0);
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      settle();
      if (bus0.rsp_valid) found = 1;
      else tick(1);
    end
    if (!found) checkOutput("backpressure.timeout", 0, 1);
    checkOutput("backpressure.rsp_result", bus0.rsp_result, 8'hA8);
    checkOutput("backpressure.rsp_carry", bus0.rsp_carry, 8'h03);
    heldRes = bus0.rsp_result;
    for (int c = 0; c < 5; c++) begin
      tick(1);
      settle();
      checkOutput("backpressure.held", bus0.rsp_result, heldRes);
      checkOutput("backpressure.busy", busy0, 1);
      checkOutput("backpressure.no_grant", bus0.req1_ready, 0);
    end
    rspReady = 1'b1;
    tick(1);
    settle();
    checkOutput("backpressure.released", bus0.rsp_valid, 0);
    checkOutput("backpressure.next_accept", bus0.req1_ready, 1);
    tick(1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick(10);

    // Reset while executing
    applyStimulus(1, 8'h77, 8'h11, 4'd1, 0, 0, 0, 0, 1);
    tick(1);
    r0v = 1'b0;
    rst = 1'b1;
    tick(1);
    settle();
    checkOutput("midreset.busy0", busy0, 0);
    checkOutput("midreset.busy1", busy1, 0);
    checkOutput("midreset.rsp_valid", bus1.rsp_valid, 0);
    checkOutput("midreset.alu_a", a1, 0);
    rst = 1'b0;
    tick(1);
    applyStimulus(1, 8'h05, 8'h06, 4'd0, 1, 8'h07, 8'h08, 4'd0, 1);
    settle();
    checkOutput("midreset.req0_wins", bus1.req0_ready, 1);
    checkOutput("midreset.req1_waits", bus1.req1_ready, 0);
    tick(1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick(8);

    // All opcodes through requester 1
    for (int op = 0; op < 16; op++) begin
      applyStimulus(0, 0, 0, 0, 1, 8'($urandom), 8'($urandom), 4'(op), 1);
      tick(1);
      r1v = 1'b0;
      tick(7);
    end

    // Randomized traffic with occasional stalls and resets
    for (int c = 0; c < 3000; c++) begin
      applyStimulus($urandom_range(0, 1), 8'($urandom), 8'($urandom), 4'($urandom),
                    $urandom_range(0, 1), 8'($urandom), 8'($urandom), 4'($urandom),
                    $urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 199) == 0);
      tick(1);
    end
    rst = 1'b0;
    tick(2);

    checkEn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
